// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus sniffer: decodes START/STOP, address/data bytes and ACK on
// slow sample strobes, and packs a transaction summary for a hex display.
module i2c_bus_monitor #(
  parameter int C_sync_stages  = 2,
  parameter int C_data_bytes   = 6,
  parameter int C_display_bits = 64
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      clk_en,
  input  logic                      scl,
  input  logic                      sda,
  output logic [C_display_bits-1:0] display,
  output logic                      byte_valid,
  output logic [7:0]                byte_data,
  output logic                      byte_ack,
  output logic                      byte_is_addr,
  output logic                      busy
);

  localparam int DataBits = 8 * C_data_bytes;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  logic [C_sync_stages-1:0] sclSync_q, sdaSync_q;
  logic                     sclNow, sdaNow;
  logic                     sampScl_q, sampSda_q;
  logic                     evStart, evStop, evRise;

  state_t                   state_q, state_d;
  logic [3:0]               bitCnt_q, bitCnt_d;
  logic [7:0]               shreg_q, shreg_d;
  logic [7:0]               addr_q, addr_d;
  logic [7:0]               byteCount_q, byteCount_d;
  logic [DataBits-1:0]      data_q, data_d;
  logic [7:0]               byteData_q, byteData_d;
  logic                     byteAck_q, byteAck_d;
  logic                     byteIsAddr_q, byteIsAddr_d;
  logic                     byteValid_q, byteValid_d;
  logic                     busy_q, busy_d;

  // Synchronisers reset to 1 so a released reset looks like an idle bus.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclSync_q <= '1;
      sdaSync_q <= '1;
      sampScl_q <= 1'b1;
      sampSda_q <= 1'b1;
    end else begin
      sclSync_q <= {sclSync_q[C_sync_stages-2:0], scl};
      sdaSync_q <= {sdaSync_q[C_sync_stages-2:0], sda};
      if (clk_en) begin
        sampScl_q <= sclNow;
        sampSda_q <= sdaNow;
      end
    end
  end

  assign sclNow = sclSync_q[C_sync_stages-1];
  assign sdaNow = sdaSync_q[C_sync_stages-1];

  // sampScl_q/sampSda_q are the previous sample; requiring SCL high in both
  // samples keeps a simultaneous SCL+SDA change from reading as START/STOP.
  assign evStart = clk_en & sampScl_q & sclNow & sampSda_q & ~sdaNow;
  assign evStop  = clk_en & sampScl_q & sclNow & ~sampSda_q & sdaNow;
  assign evRise  = clk_en & ~sampScl_q & sclNow;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      bitCnt_q     <= '0;
      shreg_q      <= '0;
      addr_q       <= '0;
      byteCount_q  <= '0;
      data_q       <= '0;
      byteData_q   <= '0;
      byteAck_q    <= 1'b0;
      byteIsAddr_q <= 1'b0;
      byteValid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitCnt_q     <= bitCnt_d;
      shreg_q      <= shreg_d;
      addr_q       <= addr_d;
      byteCount_q  <= byteCount_d;
      data_q       <= data_d;
      byteData_q   <= byteData_d;
      byteAck_q    <= byteAck_d;
      byteIsAddr_q <= byteIsAddr_d;
      byteValid_q  <= byteValid_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bitCnt_d     = bitCnt_q;
    shreg_d      = shreg_q;
    addr_d       = addr_q;
    byteCount_d  = byteCount_q;
    data_d       = data_q;
    byteData_d   = byteData_q;
    byteAck_d    = byteAck_q;
    byteIsAddr_d = byteIsAddr_q;
    byteValid_d  = 1'b0;
    busy_d       = busy_q;

    case (state_q)
      IDLE: begin
        if (evStart) begin
          state_d     = ADDR;
          busy_d      = 1'b1;
          bitCnt_d    = '0;
          byteCount_d = '0;
          data_d      = '0;
        end
      end
      default: begin
        if (evStart) begin
          state_d  = ADDR;
          bitCnt_d = '0;
        end else if (evStop) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          bitCnt_d = '0;
        end else if (evRise) begin
          if (bitCnt_q == 4'd8) begin
            // Ninth rise is the ACK slot: publish the byte even when NACKed.
            byteData_d   = shreg_q;
            byteAck_d    = ~sdaNow;
            byteIsAddr_d = (state_q == ADDR);
            byteValid_d  = 1'b1;
            bitCnt_d     = '0;
            if (state_q == ADDR) begin
              addr_d  = shreg_q;
              state_d = DATA;
            end else begin
              data_d = (data_q << 8) | DataBits'(shreg_q);
              if (byteCount_q != 8'hFF) begin
                byteCount_d = byteCount_q + 8'd1;
              end
            end
          end else begin
            shreg_d  = {shreg_q[6:0], sdaNow};
            bitCnt_d = bitCnt_q + 4'd1;
          end
        end
      end
    endcase
  end

  assign display      = {addr_q, byteCount_q, data_q};
  assign byte_valid   = byteValid_q;
  assign byte_data    = byteData_q;
  assign byte_ack     = byteAck_q;
  assign byte_is_addr = byteIsAddr_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: a table of complete transactions plus
// hand-written sequences for repeated START, saturation, glitches and reset.
module tb_i2c_bus_monitor;

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic        clkEn  = 1'b0;
  logic        scl    = 1'b1;
  logic        sda    = 1'b1;
  logic [63:0] display;
  logic        byteValid;
  logic [7:0]  byteData;
  logic        byteAck;
  logic        byteIsAddr;
  logic        busy;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       ack;
    logic       isAddr;
  } rec_t;

  typedef struct {
    int          nBytes;
    logic [79:0] bytes;
    logic [9:0]  ack;
    logic [63:0] expDisplay;
  } vec_t;

  rec_t pulses[$];
  logic bvPrev = 1'b0;
  vec_t vecs[3];

  always #20 clk = ~clk;

  i2c_bus_monitor dut (
    .clk         (clk),
    .resetn      (resetn),
    .clk_en      (clkEn),
    .scl         (scl),
    .sda         (sda),
    .display     (display),
    .byte_valid  (byteValid),
    .byte_data   (byteData),
    .byte_ack    (byteAck),
    .byte_is_addr(byteIsAddr),
    .busy        (busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic checkPulse(input string name, input int idx, input rec_t exp);
    checkOutput(name, (idx < pulses.size()) ? 64'(pulses[idx]) : 64'hFFFF_FFFF, 64'(exp));
  endtask

  // Record every byte strobe and flag any strobe lasting two clocks.
  always @(negedge clk) begin
    if (byteValid) begin
      pulses.push_back('{byteData, byteAck, byteIsAddr});
      checkOutput("byte_valid single-cycle", 64'(bvPrev), 64'd0);
    end
    bvPrev = byteValid;
  end

  // One bus sample: set the lines, let the synchroniser settle, pulse clk_en.
  task automatic applyStimulus(input logic s, input logic d);
    @(negedge clk);
    scl = s;
    sda = d;
    repeat (3) @(negedge clk);
    clkEn = 1'b1;
    @(negedge clk);
    clkEn = 1'b0;
  endtask

  task automatic sendStart();
    if (scl == 1'b0) begin
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1);
    end
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic sendStop();
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic ack, input logic expectPulse);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b0, b[i]);
      applyStimulus(1'b1, b[i]);
    end
    applyStimulus(1'b0, ~ack);
    applyStimulus(1'b1, ~ack);
    if (expectPulse) checkOutput("byte_valid latency", 64'(byteValid), 64'd1);
    applyStimulus(1'b0, ~ack);
  endtask

  initial begin
    logic [7:0] b;
    vecs[0] = '{3, 80'hDE0080_00000000000000, 10'h3FF, 64'hDE02_0000_0000_0080};
    vecs[1] = '{9, 80'hA00102030405060708_00, 10'h3FF, 64'hA008_0304_0506_0708};
    vecs[2] = '{2, 80'h3C55_0000000000000000, 10'h3FD, 64'h3C01_0000_0000_0055};

    repeat (3) @(negedge clk);
    checkOutput("reset display", display, 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset byte_valid", 64'(byteValid), 64'd0);
    checkOutput("reset byte_data", 64'(byteData), 64'd0);
    checkOutput("reset byte_ack", 64'(byteAck), 64'd0);
    checkOutput("reset byte_is_addr", 64'(byteIsAddr), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Aborted address byte: STOP after four bits.
    pulses.delete();
    sendStart();
    checkOutput("partial busy after START", 64'(busy), 64'd1);
    b = 8'hA0;
    for (int i = 7; i >= 4; i--) begin
      applyStimulus(1'b0, b[i]);
      applyStimulus(1'b1, b[i]);
    end
    sendStop();
    checkOutput("partial busy after STOP", 64'(busy), 64'd0);
    checkOutput("partial pulse count", 64'(pulses.size()), 64'd0);
    checkOutput("partial display", display, 64'd0);

    for (int v = 0; v < 3; v++) begin
      pulses.delete();
      sendStart();
      for (int i = 0; i < vecs[v].nBytes; i++)
        sendByte(vecs[v].bytes[79-8*i -: 8], vecs[v].ack[i], 1'b1);
      checkOutput("table busy before STOP", 64'(busy), 64'd1);
      sendStop();
      checkOutput("table busy after STOP", 64'(busy), 64'd0);
      checkOutput("table display", display, vecs[v].expDisplay);
      checkOutput("table pulse count", 64'(pulses.size()), 64'(vecs[v].nBytes));
      for (int i = 0; i < vecs[v].nBytes; i++)
        checkPulse("table byte record", i,
                   '{vecs[v].bytes[79-8*i -: 8], vecs[v].ack[i], (i == 0)});
      checkOutput("table held byte_ack", 64'(byteAck), 64'(vecs[v].ack[vecs[v].nBytes-1]));
    end

    // Repeated START keeps count and data, replaces the address.
    pulses.delete();
    sendStart();
    sendByte(8'hDE, 1'b1, 1'b1);
    sendByte(8'h00, 1'b1, 1'b1);
    sendStart();
    checkOutput("rstart busy", 64'(busy), 64'd1);
    sendByte(8'hDF, 1'b1, 1'b1);
    sendByte(8'h12, 1'b0, 1'b1);
    sendStop();
    checkOutput("rstart display", display, 64'hDF02_0000_0000_0012);
    checkOutput("rstart byte_ack", 64'(byteAck), 64'd0);
    checkOutput("rstart byte_data", 64'(byteData), 64'h12);
    checkOutput("rstart byte_is_addr", 64'(byteIsAddr), 64'd0);
    checkOutput("rstart pulse count", 64'(pulses.size()), 64'd4);
    checkPulse("rstart rec0", 0, '{8'hDE, 1'b1, 1'b1});
    checkPulse("rstart rec1", 1, '{8'h00, 1'b1, 1'b0});
    checkPulse("rstart rec2", 2, '{8'hDF, 1'b1, 1'b1});
    checkPulse("rstart rec3", 3, '{8'h12, 1'b0, 1'b0});

    // 256 data bytes: byte_count stops at 255.
    pulses.delete();
    sendStart();
    sendByte(8'h50, 1'b1, 1'b0);
    for (int k = 0; k < 256; k++) sendByte(8'(k), 1'b1, 1'b0);
    sendStop();
    checkOutput("saturate display", display, 64'h50FF_FAFB_FCFD_FEFF);
    checkOutput("saturate pulse count", 64'(pulses.size()), 64'd257);

    // Simultaneous SCL+SDA changes while idle must not start a transfer.
    applyStimulus(1'b0, 1'b0);
    checkOutput("idle toggle fall busy", 64'(busy), 64'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("idle toggle rise busy", 64'(busy), 64'd0);
    checkOutput("idle toggle display", display, 64'h50FF_FAFB_FCFD_FEFF);

    // Address 0xA5 with simultaneous toggles and an unsampled glitch.
    pulses.delete();
    sendStart();
    applyStimulus(1'b1, 1'b1);
    checkOutput("toggle rise not STOP", 64'(busy), 64'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("toggle fall not START", 64'(busy), 64'd1);
    b = 8'hA5;
    for (int i = 6; i >= 0; i--) begin
      if (i == 3) begin
        @(negedge clk) scl = 1'b0;
        @(negedge clk) sda = 1'b1;
        @(negedge clk) scl = 1'b1;
        @(negedge clk) scl = 1'b0;
        @(negedge clk) sda = 1'b0;
        @(negedge clk) scl = 1'b1;
        repeat (4) @(negedge clk);
      end
      applyStimulus(1'b0, b[i]);
      applyStimulus(1'b1, b[i]);
    end
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    sendStop();
    checkOutput("toggle pulse count", 64'(pulses.size()), 64'd1);
    checkPulse("toggle rec", 0, '{8'hA5, 1'b1, 1'b1});
    checkOutput("toggle display", display, 64'hA500_0000_0000_0000);

    // Reset in the middle of a byte, then a clean transfer.
    pulses.delete();
    sendStart();
    b = 8'hC3;
    for (int i = 7; i >= 4; i--) begin
      applyStimulus(1'b0, b[i]);
      applyStimulus(1'b1, b[i]);
    end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checkOutput("midreset display", display, 64'd0);
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset byte_data", 64'(byteData), 64'd0);
    checkOutput("midreset byte_ack", 64'(byteAck), 64'd0);
    checkOutput("midreset byte_is_addr", 64'(byteIsAddr), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(1'b0, b[i]);
      applyStimulus(1'b1, b[i]);
    end
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("midreset ignored pulses", 64'(pulses.size()), 64'd0);
    checkOutput("midreset ignored busy", 64'(busy), 64'd0);
    sendStart();
    sendByte(8'hA0, 1'b1, 1'b1);
    sendStop();
    checkOutput("post-reset pulse count", 64'(pulses.size()), 64'd1);
    checkPulse("post-reset rec", 0, '{8'hA0, 1'b1, 1'b1});
    checkOutput("post-reset display", display, 64'hA000_0000_0000_0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/i2c_bus_monitor.md
Name: i2c_bus_monitor

Overview:
- Passive I2C sniffer on the bridged bus (RTC/gpdi side SDA/SCL lines, input-only, never drives).
- Decodes START, STOP, address byte, data bytes and ACK/NACK, using the same slow clock-enable pulse as the bridge.
- Packs a 64-bit summary of the current/last transaction for the hex display, and emits a per-byte strobe for optional logging.

Parameters:
- C_sync_stages, 2, metastability flops on scl/sda; run every clk, min 2.
- C_data_bytes, 6, data bytes kept in display[8*C_data_bytes-1:0].
- C_display_bits, 64, must equal 16+8*C_data_bytes.

Ports:
- clk  in  1  system clock (25 MHz).
- resetn  in  1  asynchronous active-low reset.
- clk_en  in  1  one-clk sample strobe (2.77 MHz bridge enable).
- scl  in  1  raw bus SCL.
- sda  in  1  raw bus SDA.
- display  out  C_display_bits  {addr_byte[7:0], byte_count[7:0], data bytes, newest in [7:0]}.
- byte_valid  out  1  one-clk pulse per completed byte incl. ACK bit.
- byte_data  out  8  byte just completed; held until next byte.
- byte_ack  out  1  1 = ACK (SDA low on 9th bit); held with byte_data.
- byte_is_addr  out  1  byte_data is an address byte; held.
- busy  out  1  high between START and STOP.

Behaviour:
- Reset (async, resetn=0): all outputs 0, sync flops 1 (idle bus), prev samples 1, state IDLE, bit_cnt 0. Release is synchronous to clk.
- Sync: scl/sda pass through C_sync_stages flops every clk.
- Sampling: on clk_en, synced values load into cur_scl/cur_sda, and old cur values load into prev_*. All events are decoded only in clk_en cycles, from prev vs. cur.
- Event decode, one per clk_en, in priority order:
  - SCL changed in the same sample as SDA: treat as SCL edge only; no START/STOP.
  - START: prev_scl=cur_scl=1, prev_sda=1, cur_sda=0.
  - STOP: prev_scl=cur_scl=1, prev_sda=0, cur_sda=1.
  - RISE: prev_scl=0, cur_scl=1; shift in cur_sda.
- States: IDLE, ADDR, DATA.
  - IDLE: START -> ADDR. busy<=1, bit_cnt<=0, byte_count<=0, data field cleared to 0. RISE and STOP are ignored.
  - ADDR/DATA: each RISE does bit_cnt<=bit_cnt+1.
    - bit_cnt 0..7: shift sda MSB-first into shreg.
    - bit_cnt 8 (ACK bit): byte_data<=shreg, byte_ack<=~cur_sda, byte_is_addr<=(state==ADDR), byte_valid pulses on the following clk, bit_cnt<=0.
    - ADDR: display[63:56]<=shreg, then ->DATA.
    - DATA: data field shifts left 8 with shreg at [7:0], oldest byte dropped; byte_count<=byte_count+1, saturating at 255.
    - A NACKed byte is still recorded; the state is unchanged.
  - Repeated START in ADDR/DATA: ->ADDR, bit_cnt<=0. byte_count and data are preserved; the address is overwritten when the next address byte completes.
  - STOP in any non-IDLE state: ->IDLE, busy<=0. A partial byte is discarded with no byte_valid. display holds the last values until the next START from IDLE.
- Latency: byte_valid asserts exactly 1 clk after the clk_en cycle that samples the 9th SCL rise.
- byte_valid is never high in two consecutive clks.
- Reset mid-transfer: returns to IDLE; bits are ignored until the next START.

Test Plan:
- Write 0xDE (MCP7940N 0x6F, W), reg 0x00, data 0x80, all ACK, then STOP -> three byte_valid pulses: (0xDE, ack=1, is_addr=1), (0x00, 1, 0), (0x80, 1, 0). Final display=0xDE02_0000_0000_0080, busy=0.
- Write 0xDE, 0x00, then repeated START, 0xDF, read 0x12 with master NACK, then STOP -> addr field 0xDF, byte_count 0x02, data[15:0]=0x0012, last byte_ack=0. display=0xDF02_0000_0000_0012.
- Addr + 8 data bytes 0x01..0x08 -> byte_count 0x08, data field=0x0304_0506_0708, 0x01/0x02 dropped.
- START, 4 address bits, STOP -> no byte_valid, busy 1->0, display unchanged from prior state.
- SCL and SDA toggling in the same clk_en sample while SCL is high -> no START/STOP detected. Bits toggled with clk_en=0 are not sampled.
- resetn pulsed low mid-byte -> outputs 0 immediately. The following bits are ignored until the next START, then a clean decode of 0xA0 with ACK.
